// File: rtl/decode_hazard_ctrl.sv
// decode_hazard_ctrl
//   Decode-stage sequencer. Keeps a per-register count of in-flight writers,
//   stalls fetch/decode on read-after-write hazards and on writer-count
//   overflow, bubbles decode/execute on taken branches, and holds fetch while
//   an instruction that writes R15 (the PC) drains to writeback.
//
// Ports
//   clk, reset     clock; synchronous active-high reset
//   ValidD         decode stage holds a real instruction
//   RA1D/RA2D      decode read addresses, Use1D/Use2D qualify them
//   RegWriteD      decode instruction writes WA3D
//   RegWriteW      writeback enable, WA3W writeback address
//   BranchTakenE   branch in execute resolved taken this cycle
//   StallF/StallD  hold PC and F/D register
//   FlushD/FlushE  clear F/D and D/E registers
//   IssueD         instruction leaves decode this cycle
//   PendingMask    bit r set while register r has an in-flight writer

module decode_hazard_ctrl #(
    parameter int NREGS = 16,
    parameter int CNTW  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ValidD,
    input  logic [3:0]       RA1D,
    input  logic [3:0]       RA2D,
    input  logic             Use1D,
    input  logic             Use2D,
    input  logic             RegWriteD,
    input  logic [3:0]       WA3D,
    input  logic             RegWriteW,
    input  logic [3:0]       WA3W,
    input  logic             BranchTakenE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic             IssueD,
    output logic [NREGS-1:0] PendingMask
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_PCWAIT = 1'b1
    } state_t;

    localparam logic [3:0]      PC_REG  = 4'd15;
    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
    localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

    state_t          state_q, state_d;
    logic [CNTW-1:0] cnt_q [NREGS];
    logic [CNTW-1:0] cnt_d [NREGS];

    logic [NREGS-1:0] pending;
    logic [NREGS-1:0] busy;
    logic             raw;
    logic             full;
    logic             hazard;

    // A register whose last in-flight writer is writing back right now is
    // already readable: the register file writes through to the read ports.
    always_comb begin
        pending = '0;
        busy    = '0;
        for (int r = 0; r < NREGS; r++) begin
            if (4'(r) != PC_REG) begin
                busy[r]    = (cnt_q[r] != '0);
                pending[r] = busy[r] &&
                             !(RegWriteW && (WA3W == 4'(r)) && (cnt_q[r] == CNT_ONE));
            end
        end
    end

    // Full means a further writer would overflow the counter, so it must wait.
    always_comb begin
        raw    = ValidD && ((Use1D && pending[RA1D]) || (Use2D && pending[RA2D]));
        full   = ValidD && RegWriteD && (WA3D != PC_REG) && (cnt_q[WA3D] == CNT_MAX);
        hazard = raw || full;
    end

    // Output priority: taken branch, then PC wait, then hazard, then issue.
    // Reset forces every output low regardless of the inputs.
    always_comb begin
        StallF      = 1'b0;
        StallD      = 1'b0;
        FlushD      = 1'b0;
        FlushE      = 1'b0;
        IssueD      = 1'b0;
        PendingMask = '0;
        state_d     = state_q;
        if (!reset) begin
            PendingMask = busy;
            if (BranchTakenE) begin
                FlushD  = 1'b1;
                FlushE  = 1'b1;
                state_d = ST_RUN;
            end else if (state_q == ST_PCWAIT) begin
                StallF = 1'b1;
                FlushD = 1'b1;
                FlushE = 1'b1;
                if (RegWriteW && (WA3W == PC_REG)) begin
                    state_d = ST_RUN;
                end
            end else if (hazard) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end else begin
                IssueD = ValidD;
                if (ValidD && RegWriteD && (WA3D == PC_REG)) begin
                    state_d = ST_PCWAIT;
                end
            end
        end
    end

    // Simultaneous issue and writeback to the same register cancel out.
    // A writeback to a zero counter (e.g. after reset) is ignored.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            logic inc;
            logic dec;
            inc = IssueD && RegWriteD && (WA3D == 4'(r)) && (4'(r) != PC_REG);
            dec = RegWriteW && (WA3W == 4'(r)) && (cnt_q[r] != '0);
            cnt_d[r] = cnt_q[r];
            if (inc && !dec) begin
                cnt_d[r] = cnt_q[r] + CNT_ONE;
            end else if (dec && !inc) begin
                cnt_d[r] = cnt_q[r] - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            for (int r = 0; r < NREGS; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            state_q <= state_d;
            for (int r = 0; r < NREGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// tb_decode_hazard_ctrl
//   Drives directed decode/writeback sequences into decode_hazard_ctrl and
//   compares every output every cycle against a behavioural model of the
//   scoreboard, plus literal expectations on the key cycles of each sequence.

module tb_decode_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        ValidD;
    logic [3:0]  RA1D;
    logic [3:0]  RA2D;
    logic        Use1D;
    logic        Use2D;
    logic        RegWriteD;
    logic [3:0]  WA3D;
    logic        RegWriteW;
    logic [3:0]  WA3W;
    logic        BranchTakenE;
    logic        StallF;
    logic        StallD;
    logic        FlushD;
    logic        FlushE;
    logic        IssueD;
    logic [15:0] PendingMask;

    int compared   = 0;
    int mismatched = 0;

    int mcnt [16];
    bit mpcwait = 1'b0;

    decode_hazard_ctrl #(.NREGS(16), .CNTW(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .ValidD       (ValidD),
        .RA1D         (RA1D),
        .RA2D         (RA2D),
        .Use1D        (Use1D),
        .Use2D        (Use2D),
        .RegWriteD    (RegWriteD),
        .WA3D         (WA3D),
        .RegWriteW    (RegWriteW),
        .WA3W         (WA3W),
        .BranchTakenE (BranchTakenE),
        .StallF       (StallF),
        .StallD       (StallD),
        .FlushD       (FlushD),
        .FlushE       (FlushE),
        .IssueD       (IssueD),
        .PendingMask  (PendingMask)
    );

    always #5 clk = ~clk;

    // Register r blocks a reader while it has writers in flight, unless the
    // only remaining writer is writing back this very cycle.
    function automatic bit mPending(input int r);
        if (r == 15) return 1'b0;
        if (mcnt[r] == 0) return 1'b0;
        if (RegWriteW && (int'(WA3W) == r) && (mcnt[r] == 1)) return 1'b0;
        return 1'b1;
    endfunction

    // Packed as {StallF, StallD, FlushD, FlushE, IssueD, PendingMask}.
    function automatic logic [20:0] modelOut();
        bit          sf, sd, fd, fe, iss, haz;
        logic [15:0] m;
        sf = 0; sd = 0; fd = 0; fe = 0; iss = 0;
        m  = '0;
        if (reset) return '0;
        for (int r = 0; r < 16; r++) m[r] = (mcnt[r] != 0);
        haz = ValidD && ((Use1D && mPending(int'(RA1D))) || (Use2D && mPending(int'(RA2D))));
        haz = haz || (ValidD && RegWriteD && (WA3D != 4'd15) && (mcnt[WA3D] == 3));
        if (BranchTakenE) begin
            fd = 1; fe = 1;
        end else if (mpcwait) begin
            sf = 1; fd = 1; fe = 1;
        end else if (haz) begin
            sf = 1; sd = 1; fe = 1;
        end else begin
            iss = ValidD;
        end
        return {sf, sd, fd, fe, iss, m};
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state advances with the clock, using the inputs held across the edge.
    always @(posedge clk) begin
        logic [20:0] o;
        bit          incW, decW;
        o = modelOut();
        if (reset) begin
            for (int r = 0; r < 16; r++) mcnt[r] = 0;
            mpcwait = 1'b0;
        end else begin
            incW = o[16] && RegWriteD && (WA3D != 4'd15);
            decW = RegWriteW && (WA3W != 4'd15) && (mcnt[WA3W] > 0);
            if (incW) mcnt[WA3D] = mcnt[WA3D] + 1;
            if (decW) mcnt[WA3W] = mcnt[WA3W] - 1;
            if (BranchTakenE) mpcwait = 1'b0;
            else if (mpcwait) begin
                if (RegWriteW && (WA3W == 4'd15)) mpcwait = 1'b0;
            end else if (o[16] && RegWriteD && (WA3D == 4'd15)) mpcwait = 1'b1;
        end
    end

    always @(negedge clk) begin
        logic [20:0] e;
        e = modelOut();
        checkOutput("model_StallF",      {15'b0, StallF}, {15'b0, e[20]});
        checkOutput("model_StallD",      {15'b0, StallD}, {15'b0, e[19]});
        checkOutput("model_FlushD",      {15'b0, FlushD}, {15'b0, e[18]});
        checkOutput("model_FlushE",      {15'b0, FlushE}, {15'b0, e[17]});
        checkOutput("model_IssueD",      {15'b0, IssueD}, {15'b0, e[16]});
        checkOutput("model_PendingMask", PendingMask,     e[15:0]);
    end

    task automatic applyStimulus(input logic v, input logic [3:0] ra1, input logic u1,
                                 input logic [3:0] ra2, input logic u2,
                                 input logic rwd, input logic [3:0] wa3d,
                                 input logic rww, input logic [3:0] wa3w,
                                 input logic bt);
        @(posedge clk);
        #1;
        ValidD = v; RA1D = ra1; Use1D = u1; RA2D = ra2; Use2D = u2;
        RegWriteD = rwd; WA3D = wa3d; RegWriteW = rww; WA3W = wa3w;
        BranchTakenE = bt;
    endtask

    task automatic idle();
        applyStimulus(0, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0, 4'd0, 0);
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        ValidD = 0; RA1D = 0; RA2D = 0; Use1D = 0; Use2D = 0;
        RegWriteD = 0; WA3D = 0; RegWriteW = 0; WA3W = 0; BranchTakenE = 0;
        for (int r = 0; r < 16; r++) mcnt[r] = 0;
        repeat (2) @(posedge clk);
        settle();
        checkOutput("reset_StallF", {15'b0, StallF}, 16'd0);
        checkOutput("reset_IssueD", {15'b0, IssueD}, 16'd0);
        checkOutput("reset_Mask",   PendingMask,     16'h0000);
        @(posedge clk);
        #1 reset = 1'b0;

        // RAW on R1, producer writes back three cycles after issue
        applyStimulus(1, 4'd0, 0, 4'd0, 0, 1, 4'd1, 0, 4'd0, 0);
        settle(); checkOutput("s1_issue_writer", {15'b0, IssueD}, 16'd1);
        applyStimulus(1, 4'd1, 1, 4'd0, 0, 0, 4'd0, 0, 4'd0, 0);
        settle(); checkOutput("s1_stall_c1", {15'b0, StallD}, 16'd1);
        checkOutput("s1_mask", PendingMask, 16'h0002);
        checkOutput("s1_flushE_c1", {15'b0, FlushE}, 16'd1);
        applyStimulus(1, 4'd1, 1, 4'd0, 0, 0, 4'd0, 0, 4'd0, 0);
        settle(); checkOutput("s1_stall_c2", {15'b0, StallD}, 16'd1);
        applyStimulus(1, 4'd1, 1, 4'd0, 0, 0, 4'd0, 1, 4'd1, 0);
        settle(); checkOutput("s1_release_stall", {15'b0, StallD}, 16'd0);
        checkOutput("s1_release_issue", {15'b0, IssueD}, 16'd1);
        idle();
        settle(); checkOutput("s1_mask_clear", PendingMask, 16'h0000);

        // Two writers to R2, reader on port 2
        applyStimulus(1, 4'd0, 0, 4'd0, 0, 1, 4'd2, 0, 4'd0, 0);
        applyStimulus(1, 4'd0, 0, 4'd0, 0, 1, 4'd2, 0, 4'd0, 0);
        applyStimulus(1, 4'd0, 0, 4'd2, 1, 0, 4'd0, 0, 4'd0, 0);
        settle(); checkOutput("s2_stall", {15'b0, StallD}, 16'd1);
        applyStimulus(1, 4'd0, 0, 4'd2, 1, 0, 4'd0, 1, 4'd2, 0);
        settle(); checkOutput("s2_first_W_stall", {15'b0, StallD}, 16'd1);
        applyStimulus(1, 4'd0, 0, 4'd2, 1, 0, 4'd0, 1, 4'd2, 0);
        settle(); checkOutput("s2_second_W_issue", {15'b0, IssueD}, 16'd1);
        idle();
        settle(); checkOutput("s2_mask_clear", PendingMask, 16'h0000);

        // Four writers to R3: the fourth waits for a writeback
        repeat (3) applyStimulus(1, 4'd0, 0, 4'd0, 0, 1, 4'd3, 0, 4'd0, 0);
        applyStimulus(1, 4'd0, 0, 4'd0, 0, 1, 4'd3, 0, 4'd0, 0);
        settle(); checkOutput("s3_full_stall", {15'b0, StallD}, 16'd1);
        applyStimulus(1, 4'd0, 0, 4'd0, 0, 1, 4'd3, 1, 4'd3, 0);
        settle(); checkOutput("s3_full_stall_W", {15'b0, StallD}, 16'd1);
        applyStimulus(1, 4'd0, 0, 4'd0, 0, 1, 4'd3, 0, 4'd0, 0);
        settle(); checkOutput("s3_issue", {15'b0, IssueD}, 16'd1);
        applyStimulus(0, 4'd0, 0, 4'd0, 0, 0, 4'd0, 1, 4'd3, 0);
        applyStimulus(0, 4'd0, 0, 4'd0, 0, 0, 4'd0, 1, 4'd3, 0);
        applyStimulus(0, 4'd0, 0, 4'd0, 0, 0, 4'd0, 1, 4'd3, 0);
        settle(); checkOutput("s3_cnt_was_3", PendingMask, 16'h0008);
        idle();
        settle(); checkOutput("s3_mask_clear", PendingMask, 16'h0000);

        // R15 writer: PC wait until its writeback
        applyStimulus(1, 4'd0, 0, 4'd0, 0, 1, 4'd15, 0, 4'd0, 0);
        settle(); checkOutput("s4_issue_pcw", {15'b0, IssueD}, 16'd1);
        applyStimulus(1, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0, 4'd0, 0);
        settle(); checkOutput("s4_wait_stallF", {15'b0, StallF}, 16'd1);
        checkOutput("s4_wait_flushD", {15'b0, FlushD}, 16'd1);
        checkOutput("s4_wait_issue", {15'b0, IssueD}, 16'd0);
        applyStimulus(1, 4'd0, 0, 4'd0, 0, 0, 4'd0, 1, 4'd15, 0);
        settle(); checkOutput("s4_W_cycle_stallF", {15'b0, StallF}, 16'd1);
        applyStimulus(1, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0, 4'd0, 0);
        settle(); checkOutput("s4_run_stallF", {15'b0, StallF}, 16'd0);
        checkOutput("s4_run_issue", {15'b0, IssueD}, 16'd1);

        // Taken branch squashes an R15 writer that also has a RAW
        applyStimulus(1, 4'd0, 0, 4'd0, 0, 1, 4'd5, 0, 4'd0, 0);
        applyStimulus(1, 4'd5, 1, 4'd0, 0, 1, 4'd15, 0, 4'd0, 1);
        settle(); checkOutput("s5_flushD", {15'b0, FlushD}, 16'd1);
        checkOutput("s5_stallD", {15'b0, StallD}, 16'd0);
        checkOutput("s5_issue", {15'b0, IssueD}, 16'd0);
        applyStimulus(1, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0, 4'd0, 0);
        settle(); checkOutput("s5_still_run", {15'b0, StallF}, 16'd0);
        checkOutput("s5_mask", PendingMask, 16'h0020);
        applyStimulus(0, 4'd0, 0, 4'd0, 0, 0, 4'd0, 1, 4'd5, 0);
        idle();

        // Reset while R4 has two writers and the PC wait is active
        applyStimulus(1, 4'd0, 0, 4'd0, 0, 1, 4'd4, 0, 4'd0, 0);
        applyStimulus(1, 4'd0, 0, 4'd0, 0, 1, 4'd4, 0, 4'd0, 0);
        applyStimulus(1, 4'd0, 0, 4'd0, 0, 1, 4'd15, 0, 4'd0, 0);
        applyStimulus(1, 4'd4, 1, 4'd0, 0, 0, 4'd0, 0, 4'd0, 0);
        settle(); checkOutput("s6_pre_stallF", {15'b0, StallF}, 16'd1);
        checkOutput("s6_pre_mask", PendingMask, 16'h0010);
        reset = 1'b1;
        settle(); checkOutput("s6_rst_stallF", {15'b0, StallF}, 16'd0);
        checkOutput("s6_rst_flushD", {15'b0, FlushD}, 16'd0);
        checkOutput("s6_rst_mask", PendingMask, 16'h0000);
        applyStimulus(0, 4'd0, 0, 4'd0, 0, 0, 4'd0, 1, 4'd4, 0);
        reset = 1'b0;
        settle(); checkOutput("s6_post_stallF", {15'b0, StallF}, 16'd0);
        applyStimulus(1, 4'd4, 1, 4'd0, 0, 0, 4'd0, 0, 4'd0, 0);
        settle(); checkOutput("s6_read_r4_issue", {15'b0, IssueD}, 16'd1);
        checkOutput("s6_mask", PendingMask, 16'h0000);

        // Issue and ignored writeback to an idle register in the same cycle
        applyStimulus(1, 4'd0, 0, 4'd0, 0, 1, 4'd6, 1, 4'd6, 0);
        idle();
        settle(); checkOutput("s7_mask", PendingMask, 16'h0040);
        applyStimulus(0, 4'd0, 0, 4'd0, 0, 0, 4'd0, 1, 4'd6, 0);
        idle();
        settle(); checkOutput("s7_mask_clear", PendingMask, 16'h0000);

        // Mixed traffic checked by the model alone
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                          4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                          1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                          1'($urandom_range(0, 15) == 0));
            reset = ($urandom_range(0, 63) == 0);
        end
        reset = 1'b0;
        idle();

        settle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
